// File: rtl/prescaled_tick_counter.sv
// Programmable prescaler with a wrap-at-limit value counter and registered tick/wrap pulses.
// Optional down-count mode (count_down port) is enabled by defining COUNTER_DOWN_EN.
module prescaled_tick_counter #(
   parameter int unsigned WIDTH      = 4,
   parameter int unsigned PRESCALE_W = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  clear,
   input  logic [PRESCALE_W-1:0] div,
   input  logic [WIDTH-1:0]      limit,
`ifdef COUNTER_DOWN_EN
   input  logic                  count_down,
`endif
   output logic [WIDTH-1:0]      value,
   output logic                  tick,
   output logic                  wrap
);

   logic [PRESCALE_W-1:0] pre;
   logic                  rollover_c;
   logic [WIDTH-1:0]      value_nxt_c;
   logic                  wrap_nxt_c;

   // Prescaler rollover; >= lets a lowered div take effect on the next enabled edge
   assign rollover_c = (pre >= div);

   // Value update applied on a rollover edge
   always_comb begin
      value_nxt_c = value + WIDTH'(1);
      wrap_nxt_c  = 1'b0;
`ifdef COUNTER_DOWN_EN
      if (count_down) begin
         if ((value == '0) || (value > limit)) begin
            value_nxt_c = limit;
            wrap_nxt_c  = 1'b1;
         end else begin
            value_nxt_c = value - WIDTH'(1);
         end
      end else if (value >= limit) begin
         value_nxt_c = '0;
         wrap_nxt_c  = 1'b1;
      end
`else
      if (value >= limit) begin
         value_nxt_c = '0;
         wrap_nxt_c  = 1'b1;
      end
`endif
   end

   // State and registered pulses; reset > clear > enable
   always_ff @(posedge clk) begin
      if (reset) begin
         pre   <= '0;
         value <= '0;
         tick  <= 1'b0;
         wrap  <= 1'b0;
      end else if (clear) begin
         pre   <= '0;
         value <= '0;
         tick  <= 1'b0;
         wrap  <= 1'b0;
      end else if (enable) begin
         if (rollover_c) begin
            pre   <= '0;
            value <= value_nxt_c;
            tick  <= 1'b1;
            wrap  <= wrap_nxt_c;
         end else begin
            pre   <= pre + PRESCALE_W'(1);
            tick  <= 1'b0;
            wrap  <= 1'b0;
         end
      end else begin
         tick <= 1'b0;
         wrap <= 1'b0;
      end
   end

endmodule

// File: tb/tb_prescaled_tick_counter.sv
// Directed self-checking bench for prescaled_tick_counter (WIDTH=4, PRESCALE_W=6).
module tb_prescaled_tick_counter;

   logic       clk;
   logic       reset;
   logic       enable;
   logic       clear;
   logic [5:0] div;
   logic [3:0] limit;
   logic       count_down;
   logic [3:0] value;
   logic       tick;
   logic       wrap;

   int total = 0;
   int bad   = 0;

   logic [3:0] t1_val  [0:11] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd3, 4'd3, 4'd3, 4'd0};
   logic       t1_tick [0:11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
   logic       t1_wrap [0:11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   logic [3:0] t6_val  [0:4]  = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd3};
   logic       t6_wrap [0:4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

   prescaled_tick_counter #(.WIDTH(4), .PRESCALE_W(6)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .clear      (clear),
      .div        (div),
      .limit      (limit),
`ifdef COUNTER_DOWN_EN
      .count_down (count_down),
`endif
      .value      (value),
      .tick       (tick),
      .wrap       (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] ev, input logic et, input logic ew);
      chk({tag, ".value"}, 8'(value), 8'(ev));
      chk({tag, ".tick"},  8'(tick),  8'(et));
      chk({tag, ".wrap"},  8'(wrap),  8'(ew));
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; clear = 1'b0;
      div = 6'd0; limit = 4'd0; count_down = 1'b0;
      step();
      step();
      chk_all("reset", 4'd0, 1'b0, 1'b0);

      // div=2, limit=3: tick every 3rd edge, wrap on the 12th
      reset = 1'b0; enable = 1'b1; div = 6'd2; limit = 4'd3;
      for (int i = 0; i < 12; i++) begin
         step();
         chk_all($sformatf("t1_e%0d", i + 1), t1_val[i], t1_tick[i], t1_wrap[i]);
      end

      // clear wins over enable
      clear = 1'b1;
      step();
      chk_all("t2_clear", 4'd0, 1'b0, 1'b0);

      // div=0, limit=0: tick and wrap every edge, value held at 0
      clear = 1'b0; div = 6'd0; limit = 4'd0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk_all($sformatf("t2_e%0d", i + 1), 4'd0, 1'b1, 1'b1);
      end

      // div=1, limit=9: run to 5, freeze, resume
      clear = 1'b1;
      step();
      clear = 1'b0; div = 6'd1; limit = 4'd9;
      for (int i = 0; i < 10; i++) step();
      chk_all("t3_at5", 4'd5, 1'b1, 1'b0);
      enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk_all($sformatf("t3_hold%0d", i + 1), 4'd5, 1'b0, 1'b0);
      end
      enable = 1'b1;
      step();
      chk_all("t3_res1", 4'd5, 1'b0, 1'b0);
      step();
      chk_all("t3_res2", 4'd6, 1'b1, 1'b0);

      // limit lowered below value wraps on next tick
      step();
      step();
      chk_all("t4_at7", 4'd7, 1'b1, 1'b0);
      limit = 4'd4;
      step();
      chk_all("t4_pre", 4'd7, 1'b0, 1'b0);
      step();
      chk_all("t4_wrap", 4'd0, 1'b1, 1'b1);

      // same-cycle clear/reset with enable
      limit = 4'd9; div = 6'd0;
      for (int i = 0; i < 5; i++) step();
      chk_all("t5_at5a", 4'd5, 1'b1, 1'b0);
      clear = 1'b1;
      step();
      chk_all("t5_clear", 4'd0, 1'b0, 1'b0);
      clear = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk_all("t5_at5b", 4'd5, 1'b1, 1'b0);
      reset = 1'b1;
      step();
      chk_all("t5_reset", 4'd0, 1'b0, 1'b0);
      reset = 1'b0;

`ifdef COUNTER_DOWN_EN
      // down mode from 0 with limit=3
      count_down = 1'b1; div = 6'd0; limit = 4'd3;
      for (int i = 0; i < 5; i++) begin
         step();
         chk_all($sformatf("t6_e%0d", i + 1), t6_val[i], 1'b1, t6_wrap[i]);
      end
      count_down = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
